bit_recovery_cdr_param: RTL and testbench
=========================================

// Module: bit_recovery_cdr_param
// PURPOSE
//  Parametrised phase-to-bit recovery plus clock/data recovery for the FSK/MSK receive chain.
//  - Input: the phase sample stream from the demodulator.
//  - Bit decision: the sign of the wrapped phase increment.
//  - Bit timing: an oversampling counter, corrected on every bit transition.
//    Hard realign or gradual (one-step) tracking, selected by parameter.
//  - Outputs: one strobed data bit per symbol, plus a lock indicator for the packet-sync logic.
// PARAMETERS
//  PHASE_W    6   phase sample width, signed two's complement (>=3)
//  OSR        8   valid samples per bit; even, >=4
//  TRACK_MODE 0   0: hard realign on transition; 1: +/-1 step per transition
//  LOCK_BITS  8   consecutive in-window transitions needed to assert lock_o (>=1)
//  MAX_RUN    32  strobed bits without a transition before lock_o drops (>=OSR)
// PORTS
//  clk         in   1        system clock
//  resetn      in   1        asynchronous active-low reset
//  clear_i     in   1        synchronous soft clear; same effect as reset, one cycle
//  phase_i     in   PHASE_W  signed phase sample
//  ph_valid_i  in   1        phase_i valid this cycle
//  data_en_o   out  1        one-cycle strobe: data_o holds a new bit
//  data_o      out  1        recovered bit
//  lock_o      out  1        timing locked
// BEHAVIOUR
//  Reset / clear:
//  - Outputs reset to data_en_o=0, data_o=0, lock_o=0.
//  - Internal state resets to phase_prev=0, prev_ok=0, raw=0, raw_d=0, cnt=0, lock_cnt=0, run_cnt=0.
//  - Reset asserted mid-operation clears everything immediately; no partial strobe is emitted.
//  - clear_i has priority over ph_valid_i.
//  Sample handling:
//  - All state advances only on cycles with ph_valid_i=1; idle cycles freeze every counter.
//  Bit decision:
//  - dphi = phase_i - phase_prev, computed modulo 2^PHASE_W (natural wrap).
//    Example, PHASE_W=6: 31 -> -32 gives dphi=+1.
//  - dphi>0 -> raw=1; dphi<0 -> raw=0; dphi==0 -> raw holds its value.
//  - First valid sample after reset/clear only loads phase_prev and sets prev_ok; raw is unchanged.
//  Transition:
//  - Occurs on a valid sample with prev_ok=1 and the new raw != raw_d.
//  - raw_d <= raw on every valid sample.
//  Counter:
//  - Transition at count k. With no transition: cnt <= (cnt+1) mod OSR.
//  - TRACK_MODE=0: on a transition, cnt <= 1 (the transition sample is position 0).
//  - TRACK_MODE=1, applied on a transition:
//    - k==0: normal increment.
//    - 1<=k<OSR/2 (late): cnt holds.
//    - k>=OSR/2 (early): cnt <= (k+2) mod OSR.
//  Strobe:
//  - Sampled on a valid sample with prev_ok=1 and the pre-update cnt==OSR/2.
//  - Next cycle: data_en_o=1 for exactly one clk, and data_o=raw decided from that sample.
//  - Latency: 1 clk from the strobing valid sample.
//  - data_o holds its value between strobes.
//  - Tracking never skips or repeats the OSR/2 position within one bit.
//  Lock:
//  - In-window transition: k in {OSR-1, 0, 1}.
//  - In-window transition: lock_cnt saturating +1.
//    Out-of-window transition: lock_cnt=0 and lock_o=0.
//  - lock_o <= 1 when lock_cnt reaches LOCK_BITS.
//  - run_cnt counts strobes since the last transition; any transition resets it.
//  - run_cnt reaching MAX_RUN: lock_o=0 and lock_cnt=0.
//  - A transition and a strobe on the same sample: the strobe uses the pre-update cnt, and run_cnt resets.
//  - lock_o changes one clk after the deciding sample.
// TESTING
//  1. Reset: resetn=0 with ph_valid_i=1 and a ramping phase -> all outputs 0.
//     Release resetn -> first data_en_o only after at least OSR/2+1 valid samples.
//  2. Alignment: OSR=8; phase steps of +3 for 8 samples, then -3 for 8, repeating, boundaries aligned.
//     -> data_o = 1,0,1,0... with data_en_o every 8th valid sample.
//     -> lock_o=1 one clk after the 8th in-window transition.
//  3. Wrap: PHASE_W=6, samples 28,31,-30,-27 -> dphi=+3 each -> raw=1 throughout, no spurious transition.
//  4. Offset: pattern offset by 3 samples.
//     TRACK_MODE=0: -> cnt realigned at the first transition, next strobe 4 samples after it.
//     TRACK_MODE=1: -> offset drops 3->2->1->0 over three transitions; lock_o only after the error is <=1.
//  5. Valid gaps: stream of test 2 with 0-3 random idle cycles between valid samples.
//     -> identical data_o sequence; data_en_o only one cycle after a valid sample.
//  6. Loss of lock: locked, then 40 bits of constant +3 steps (MAX_RUN=32) -> lock_o falls after the 32nd transition-less strobe.
//     Then clear_i pulse -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bit_recovery_cdr_param.sv
// Phase-to-bit recovery with clock/data recovery for the FSK/MSK receive chain.
// Bits come from the sign of the wrapped phase increment; timing from a transition-corrected counter.
module bit_recovery_cdr_param #(
    parameter int unsigned PHASE_W    = 6,
    parameter int unsigned OSR        = 8,
    parameter int unsigned TRACK_MODE = 0,
    parameter int unsigned LOCK_BITS  = 8,
    parameter int unsigned MAX_RUN    = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear_i,
    input  logic [PHASE_W-1:0] phase_i,
    input  logic               ph_valid_i,
    output logic               data_en_o,
    output logic               data_o,
    output logic               lock_o
);

    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned LW = $clog2(LOCK_BITS + 1);
    localparam int unsigned RW = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] HALF = CW'(OSR / 2);
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    logic [PHASE_W-1:0] phase_prev;
    logic               prev_ok;
    logic               raw;
    logic               raw_d;
    logic [CW-1:0]      cnt;
    logic [LW-1:0]      lock_cnt;
    logic [RW-1:0]      run_cnt;

    logic [PHASE_W-1:0] dphi;
    logic               raw_new;
    logic               trans;
    logic               strobe;
    logic               in_win;
    logic [CW-1:0]      cnt_inc;
    logic [CW-1:0]      cnt_next;

    always_comb begin
        // Modulo-2^PHASE_W subtraction gives the natural wrap of the phase increment.
        dphi    = phase_i - phase_prev;
        raw_new = raw;
        if (dphi != '0) begin
            raw_new = ~dphi[PHASE_W-1];
        end
        trans   = prev_ok && (raw_new != raw_d);
        strobe  = prev_ok && (cnt == HALF);
        in_win  = (cnt == LAST) || (cnt == '0) || (cnt == CW'(1));
        cnt_inc = (cnt == LAST) ? '0 : cnt + CW'(1);

        cnt_next = cnt_inc;
        if (trans) begin
            if (TRACK_MODE == 0) begin
                cnt_next = CW'(1);
            end else if (cnt == '0) begin
                cnt_next = cnt_inc;
            end else if (cnt < HALF) begin
                cnt_next = cnt;
            end else begin
                cnt_next = CW'((int'(cnt) + 2) % int'(OSR));
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_prev <= '0;
            prev_ok    <= 1'b0;
            raw        <= 1'b0;
            raw_d      <= 1'b0;
            cnt        <= '0;
            lock_cnt   <= '0;
            run_cnt    <= '0;
            data_en_o  <= 1'b0;
            data_o     <= 1'b0;
            lock_o     <= 1'b0;
        end else if (clear_i) begin
            phase_prev <= '0;
            prev_ok    <= 1'b0;
            raw        <= 1'b0;
            raw_d      <= 1'b0;
            cnt        <= '0;
            lock_cnt   <= '0;
            run_cnt    <= '0;
            data_en_o  <= 1'b0;
            data_o     <= 1'b0;
            lock_o     <= 1'b0;
        end else begin
            data_en_o <= 1'b0;
            if (ph_valid_i) begin
                phase_prev <= phase_i;
                if (!prev_ok) begin
                    prev_ok <= 1'b1;
                end else begin
                    raw   <= raw_new;
                    raw_d <= raw_new;
                    cnt   <= cnt_next;
                    if (strobe) begin
                        data_en_o <= 1'b1;
                        data_o    <= raw_new;
                    end
                    // A transition always restarts the run length, even on a strobe sample.
                    if (trans) begin
                        run_cnt <= '0;
                        if (in_win) begin
                            if (lock_cnt != LW'(LOCK_BITS)) begin
                                lock_cnt <= lock_cnt + LW'(1);
                            end
                            if (int'(lock_cnt) + 1 >= int'(LOCK_BITS)) begin
                                lock_o <= 1'b1;
                            end
                        end else begin
                            lock_cnt <= '0;
                            lock_o   <= 1'b0;
                        end
                    end else if (strobe) begin
                        if (int'(run_cnt) + 1 >= int'(MAX_RUN)) begin
                            run_cnt  <= RW'(MAX_RUN);
                            lock_cnt <= '0;
                            lock_o   <= 1'b0;
                        end else begin
                            run_cnt <= run_cnt + RW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_recovery_cdr_param.sv
// Directed bench for bit_recovery_cdr_param: hard-realign and tracking instances on one stream.
module tb_bit_recovery_cdr_param;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clear_i = 1'b0;
    logic       ph_valid_i = 1'b0;
    logic [5:0] phase_i = '0;
    logic       en0, d0, l0, en1, d1, l1;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [5:0] ph;
    logic              last0, last1;
    logic              e0, e1;
    int                wrap_ph [6] = '{28, 31, -30, -27, -24, -21};

    always #5 clk = ~clk;

    bit_recovery_cdr_param #(
        .PHASE_W(6), .OSR(8), .TRACK_MODE(0), .LOCK_BITS(8), .MAX_RUN(32)
    ) dut0 (
        .clk(clk), .resetn(resetn), .clear_i(clear_i), .phase_i(phase_i),
        .ph_valid_i(ph_valid_i), .data_en_o(en0), .data_o(d0), .lock_o(l0)
    );

    bit_recovery_cdr_param #(
        .PHASE_W(6), .OSR(8), .TRACK_MODE(1), .LOCK_BITS(8), .MAX_RUN(32)
    ) dut1 (
        .clk(clk), .resetn(resetn), .clear_i(clear_i), .phase_i(phase_i),
        .ph_valid_i(ph_valid_i), .data_en_o(en1), .data_o(d1), .lock_o(l1)
    );

    // Aligned square wave: sample 1..8 up, 9..16 down, ...
    function automatic logic signed [5:0] dir_aligned(input int j);
        return (((j - 1) / 8) % 2 == 0) ? 6'sd3 : -6'sd3;
    endfunction

    // Same wave shifted: 3 up samples, then 8 down, 8 up, ...
    function automatic logic signed [5:0] dir_offset(input int j);
        if (j < 4) return 6'sd3;
        return (((j - 4) / 8) % 2 == 0) ? -6'sd3 : 6'sd3;
    endfunction

    task automatic chk(input string tag, input int j, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s @%0d: observed=%b expected=%b", tag, j, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input int j,
                              input logic xe0, input logic xd0, input logic xl0,
                              input logic xe1, input logic xd1, input logic xl1);
        chk({tag, "_en0"}, j, en0, xe0);
        chk({tag, "_d0"},  j, d0,  xd0);
        chk({tag, "_lk0"}, j, l0,  xl0);
        chk({tag, "_en1"}, j, en1, xe1);
        chk({tag, "_d1"},  j, d1,  xd1);
        chk({tag, "_lk1"}, j, l1,  xl1);
    endtask

    task automatic drive(input logic [5:0] p, input logic clr);
        phase_i    = p;
        ph_valid_i = 1'b1;
        clear_i    = clr;
        @(posedge clk);
        #1;
        ph_valid_i = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic idle();
        phase_i = 6'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held while a ramp streams in: nothing may come out.
        for (int i = 0; i < 4; i++) begin
            phase_i    = 6'(i * 5);
            ph_valid_i = 1'b1;
            @(posedge clk);
            #1;
            check_both("rst", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        ph_valid_i = 1'b0;
        resetn     = 1'b1;

        // Aligned stream: strobe 4 samples after each boundary, lock after 8th transition.
        last0 = 1'b0;
        ph    = '0;
        for (int j = 0; j <= 64; j++) begin
            if (j > 0) ph = ph + dir_aligned(j);
            drive(ph, 1'b0);
            e0 = (j >= 1) && (j % 8 == 5);
            if (e0) last0 = (dir_aligned(j) == 6'sd3);
            check_both("align", j, e0, last0, j >= 57, e0, last0, j >= 57);
        end

        // Constant +3: one last transition at 65, lock drops on the 32nd empty strobe (317).
        for (int j = 65; j <= 388; j++) begin
            ph = ph + 6'sd3;
            drive(ph, 1'b0);
            e0 = (j % 8 == 5);
            if (e0) last0 = 1'b1;
            check_both("run", j, e0, last0, j < 317, e0, last0, j < 317);
        end
        // Clear wins over a valid sample that would otherwise strobe.
        ph = ph + 6'sd3;
        drive(ph, 1'b1);
        check_both("clear", 389, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap across +31/-32 is still a positive step: no extra transition.
        last0 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive(6'(wrap_ph[j]), 1'b0);
            e0 = (j == 5);
            if (e0) last0 = 1'b1;
            check_both("wrap", j, e0, last0, 1'b0, e0, last0, 1'b0);
        end

        // Asynchronous reset mid-cycle clears outputs immediately.
        #2;
        resetn = 1'b0;
        #1;
        check_both("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Offset stream: hard realign strobes at j%8==0; tracking walks 3->2->1->0.
        last0 = 1'b0;
        last1 = 1'b0;
        ph    = '0;
        for (int j = 0; j <= 80; j++) begin
            if (j > 0) ph = ph + dir_offset(j);
            drive(ph, 1'b0);
            e0 = (j >= 8) && (j % 8 == 0);
            e1 = (j == 6) || (j == 15) || (j == 24) || ((j >= 32) && (j % 8 == 0));
            if (e0) last0 = (dir_offset(j) == 6'sd3);
            if (e1) last1 = (dir_offset(j) == 6'sd3);
            check_both("offset", j, e0, last0, j >= 68, e1, last1, j >= 76);
        end

        // Clear without a valid sample.
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check_both("clear2", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Aligned stream with random idle gaps: same bits, strobes only after valid samples.
        last0 = 1'b0;
        ph    = '0;
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) ph = ph + dir_aligned(j);
            drive(ph, 1'b0);
            e0 = (j >= 1) && (j % 8 == 5);
            if (e0) last0 = (dir_aligned(j) == 6'sd3);
            check_both("gap", j, e0, last0, 1'b0, e0, last0, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                idle();
                check_both("gap_idle", j, 1'b0, last0, 1'b0, 1'b0, last0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
